lzc_norm_pipe: RTL and testbench

Parametrised, pipelined leading-zero counter and normaliser for the raybox-zero fixed-point datapath. It counts leading zeros on a WIDTH-bit operand, either raw unsigned or sign-magnitude from a two's-complement input. It returns the count and the operand left-shifted so its MSB is set. The block feeds the reciprocal/divider front-ends and uses a valid/ready handshake on both sides, so it can sit between FSM-driven stages with backpressure.

---
 rtl/lzc_norm_pipe.sv | 82 ++++++++
 tb/tb_lzc_norm_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage leading-zero count and normalise with valid/ready flow control
module lzc_norm_pipe #(
  parameter int WIDTH = 22,
  localparam int LZCW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_signed,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LZCW-1:0]  o_lzc,
  output logic [WIDTH-1:0] o_norm,
  output logic             o_zero,
  output logic             o_neg
);
  logic             s1_valid_q, s1_valid_d, s1_zero_q, s1_zero_d, s1_neg_q, s1_neg_d;
  logic [WIDTH-1:0] s1_mag_q, s1_mag_d;
  logic [LZCW-1:0]  s1_lzc_q, s1_lzc_d;
  logic             s2_valid_q, s2_valid_d, s2_zero_q, s2_zero_d, s2_neg_q, s2_neg_d;
  logic [WIDTH-1:0] s2_norm_q, s2_norm_d;
  logic [LZCW-1:0]  s2_lzc_q, s2_lzc_d;
  logic             s1_adv, s2_adv, acc, s2_load, neg;
  logic [WIDTH-1:0] mag, norm;
  logic [LZCW-1:0]  lzc;
  always_comb begin
    s2_adv = !s2_valid_q || i_ready;
    s1_adv = !s1_valid_q || s2_adv;
    acc = i_valid && s1_adv;
    s2_load = s2_adv && s1_valid_q;
    neg = i_signed && i_data[WIDTH-1];
    mag = neg ? -i_data : i_data;
    lzc = LZCW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) lzc = mag[i] ? LZCW'(WIDTH - 1 - i) : lzc;
    // log2 barrel: stage k shifts by 2**k when bit k of the count is set
    norm = s1_mag_q;
    for (int k = 0; k < LZCW; k++) norm = s1_lzc_q[k] ? norm << (1 << k) : norm;
    s1_valid_d = s1_adv ? i_valid : s1_valid_q;
    s1_mag_d = acc ? mag : s1_mag_q;
    s1_lzc_d = acc ? lzc : s1_lzc_q;
    s1_zero_d = acc ? (mag == '0) : s1_zero_q;
    s1_neg_d = acc ? neg : s1_neg_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_norm_d = s2_load ? norm : s2_norm_q;
    s2_lzc_d = s2_load ? s1_lzc_q : s2_lzc_q;
    s2_zero_d = s2_load ? s1_zero_q : s2_zero_q;
    s2_neg_d = s2_load ? s1_neg_q : s2_neg_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_mag_q <= '0;
      s1_lzc_q <= '0;
      s1_zero_q <= 1'b0;
      s1_neg_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_norm_q <= '0;
      s2_lzc_q <= '0;
      s2_zero_q <= 1'b0;
      s2_neg_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mag_q <= s1_mag_d;
      s1_lzc_q <= s1_lzc_d;
      s1_zero_q <= s1_zero_d;
      s1_neg_q <= s1_neg_d;
      s2_valid_q <= s2_valid_d;
      s2_norm_q <= s2_norm_d;
      s2_lzc_q <= s2_lzc_d;
      s2_zero_q <= s2_zero_d;
      s2_neg_q <= s2_neg_d;
    end
  end
  assign o_ready = s1_adv;
  assign o_valid = s2_valid_q;
  assign o_lzc = s2_lzc_q;
  assign o_norm = s2_norm_q;
  assign o_zero = s2_zero_q;
  assign o_neg = s2_neg_q;
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb_lzc_norm_pipe: randomized and directed checks of lzc_norm_pipe at widths 22, 17, 24 and 30
module tb_lzc_norm_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic vin [4], sgn [4], rdy [4], ordy [4], ov [4], oz [4], ong [4];
  logic [31:0] din [4], onorm [4];
  logic [5:0] olzc [4];
  int pass_cnt = 0, tot_cnt = 0;
  function automatic int wof(input int g);
    return g == 0 ? 22 : g == 1 ? 17 : g == 2 ? 24 : 30;
  endfunction
  for (genvar g = 0; g < 4; g++) begin : ln
    localparam int W = wof(g);
    logic [W-1:0] nw;
    logic [$clog2(W+1)-1:0] lw;
    lzc_norm_pipe #(.WIDTH(W)) u (
      .clk(clk), .reset(reset), .i_valid(vin[g]), .o_ready(ordy[g]),
      .i_data(din[g][W-1:0]), .i_signed(sgn[g]), .o_valid(ov[g]), .i_ready(rdy[g]),
      .o_lzc(lw), .o_norm(nw), .o_zero(oz[g]), .o_neg(ong[g])
    );
    assign onorm[g] = 32'(nw);
    assign olzc[g] = 6'(lw);
  end
  // reference: count = width minus bit length of the magnitude
  function automatic void refm(input int w, input logic [31:0] x, input logic s,
                               output logic [5:0] lz, output logic [31:0] nm,
                               output logic z, output logic ng);
    longint mask, m;
    int n;
    mask = (longint'(1) << w) - 1;
    m = longint'(x) & mask;
    ng = s && x[w-1];
    if (ng) m = ((longint'(1) << w) - m) & mask;
    n = w - $clog2(m + 1);
    lz = 6'(n);
    nm = 32'((m << n) & mask);
    z = m == 0;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    for (int g = 0; g < 4; g++) begin
      vin[g] = 1'b0;
      sgn[g] = 1'b0;
      rdy[g] = 1'b1;
      din[g] = 32'd0;
    end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      tot_cnt++;
      if ({ov[g], olzc[g], onorm[g], oz[g], ong[g], ordy[g]} !== {1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1})
        $display("FAIL reset lane%0d: v=%b lzc=%0d norm=%h z=%b n=%b rdy=%b, want 0/0/0/0/0/1",
                 g, ov[g], olzc[g], onorm[g], oz[g], ong[g], ordy[g]);
      else pass_cnt++;
    end
    reset = 1'b0;
    tick;
    tot_cnt++;
    if (ov[0] !== 1'b0 || ordy[0] !== 1'b1)
      $display("FAIL post_reset: v=%b rdy=%b, want 0/1", ov[0], ordy[0]);
    else pass_cnt++;
  endtask
  task automatic test_directed;
    logic [21:0] dv [6];
    logic [21:0] en [6];
    bit sv [6], eg [6], ez [6];
    int el [6];
    dv = '{22'h000001, 22'h000000, 22'h200000, 22'h3FFFFF, 22'h200000, 22'h3FF800};
    sv = '{0, 0, 0, 1, 1, 1};
    el = '{21, 22, 0, 21, 0, 10};
    en = '{22'h200000, 22'h0, 22'h200000, 22'h200000, 22'h200000, 22'h200000};
    ez = '{0, 1, 0, 0, 0, 0};
    eg = '{0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      din[0] = 32'(dv[i]);
      sgn[0] = sv[i];
      vin[0] = 1'b1;
      rdy[0] = 1'b1;
      tick;
      vin[0] = 1'b0;
      tick;
      tot_cnt++;
      if ({ov[0], olzc[0], onorm[0], oz[0], ong[0]} !== {1'b1, 6'(el[i]), 32'(en[i]), ez[i], eg[i]})
        $display("FAIL directed%0d: v=%b lzc=%0d norm=%h z=%b n=%b, want 1/%0d/%h/%b/%b",
                 i, ov[0], olzc[0], onorm[0], oz[0], ong[0], el[i], en[i], ez[i], eg[i]);
      else pass_cnt++;
      tick;
    end
  endtask
  task automatic test_backpressure;
    logic [21:0] sv4 [4];
    int el [4];
    int got [$];
    int gotc [$];
    int n = 0;
    sv4 = '{22'h000003, 22'h0000F0, 22'h100000, 22'h000000};
    el = '{20, 14, 1, 22};
    sgn[0] = 1'b0;
    for (int c = 0; c < 30 && got.size() < 4; c++) begin
      vin[0] = n < 4;
      din[0] = 32'(sv4[n < 4 ? n : 3]);
      rdy[0] = !(c >= 2 && c <= 5);
      #1;
      if (c >= 2 && c <= 5) begin
        tot_cnt++;
        if (ov[0] !== 1'b1 || olzc[0] !== 6'd20 || ordy[0] !== 1'b0 || n != 2)
          $display("FAIL stall c%0d: v=%b lzc=%0d rdy=%b accepts=%0d, want 1/20/0/2",
                   c, ov[0], olzc[0], ordy[0], n);
        else pass_cnt++;
      end
      if (ov[0] && rdy[0]) begin
        got.push_back(int'(olzc[0]));
        gotc.push_back(c);
      end
      if (vin[0] && ordy[0]) n++;
      tick;
    end
    vin[0] = 1'b0;
    rdy[0] = 1'b1;
    tot_cnt++;
    if (got.size() != 4) $display("FAIL bp_count: got %0d results, want 4", got.size());
    else pass_cnt++;
    for (int i = 0; i < got.size() && i < 4; i++) begin
      tot_cnt++;
      if (got[i] != el[i] || gotc[i] != gotc[0] + i)
        $display("FAIL bp_order%0d: lzc=%0d at cycle %0d, want %0d at cycle %0d",
                 i, got[i], gotc[i], el[i], gotc[0] + i);
      else pass_cnt++;
    end
  endtask
  task automatic test_random(input int g);
    logic [5:0] ql [$];
    logic [31:0] qn [$];
    logic qz [$], qg [$];
    int qe [$];
    logic [5:0] lz, el;
    logic [31:0] nm, en, x, mask;
    logic z, ng, ez, eg;
    int sent = 0, w, ea;
    w = wof(g);
    mask = 32'((longint'(1) << w) - 1);
    for (int c = 0; c < 300 && (sent < 64 || ql.size() > 0); c++) begin
      case ($urandom_range(0, 7))
        0: x = 32'd0;
        1: x = 32'd1 << (w - 1);
        2: x = 32'd1 << $urandom_range(0, w - 1);
        default: x = $urandom & mask;
      endcase
      if (sent == 0) x = 32'd0;
      vin[g] = sent < 64;
      din[g] = x;
      sgn[g] = sent == 0 ? 1'b0 : 1'($urandom_range(0, 1));
      rdy[g] = 1'b1;
      #1;
      if (vin[g]) begin
        tot_cnt++;
        if (ordy[g] !== 1'b1) $display("FAIL rand_ready w%0d c%0d: rdy=%b, want 1", w, c, ordy[g]);
        else pass_cnt++;
      end
      if (ov[g] && rdy[g]) begin
        tot_cnt++;
        if (ql.size() == 0) $display("FAIL rand_extra w%0d c%0d: unexpected result lzc=%0d", w, c, olzc[g]);
        else begin
          el = ql.pop_front();
          en = qn.pop_front();
          ez = qz.pop_front();
          eg = qg.pop_front();
          ea = qe.pop_front();
          if ({olzc[g], onorm[g], oz[g], ong[g]} !== {el, en, ez, eg} || c != ea + 2)
            $display("FAIL rand w%0d c%0d: lzc=%0d norm=%h z=%b n=%b, want %0d/%h/%b/%b at cycle %0d",
                     w, c, olzc[g], onorm[g], oz[g], ong[g], el, en, ez, eg, ea + 2);
          else pass_cnt++;
          tot_cnt++;
          if (ez ? olzc[g] !== 6'(w) : onorm[g][w-1] !== 1'b1)
            $display("FAIL rand_edge w%0d c%0d: lzc=%0d norm=%h zero=%b, want lzc=%0d or norm msb 1",
                     w, c, olzc[g], onorm[g], ez, w);
          else pass_cnt++;
        end
      end
      if (vin[g] && ordy[g]) begin
        refm(w, x, sgn[g], lz, nm, z, ng);
        ql.push_back(lz);
        qn.push_back(nm);
        qz.push_back(z);
        qg.push_back(ng);
        qe.push_back(c);
        sent++;
      end
      tick;
    end
    vin[g] = 1'b0;
    tot_cnt++;
    if (sent != 64 || ql.size() != 0)
      $display("FAIL rand_timeout w%0d: sent=%0d pending=%0d, want 64/0", w, sent, ql.size());
    else pass_cnt++;
  endtask
  task automatic test_reset_mid;
    rdy[0] = 1'b0;
    vin[0] = 1'b1;
    sgn[0] = 1'b0;
    din[0] = 32'h5;
    tick;
    din[0] = 32'h7;
    tick;
    vin[0] = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    tot_cnt++;
    if (ov[0] !== 1'b0 || olzc[0] !== 6'd0 || ordy[0] !== 1'b1)
      $display("FAIL reset_mid: v=%b lzc=%0d rdy=%b, want 0/0/1", ov[0], olzc[0], ordy[0]);
    else pass_cnt++;
    #2;
    reset = 1'b0;
    rdy[0] = 1'b1;
    tick;
    vin[0] = 1'b1;
    din[0] = 32'h10;
    #1;
    tot_cnt++;
    if (ov[0] !== 1'b0) $display("FAIL reset_stale0: v=%b, want 0", ov[0]);
    else pass_cnt++;
    tick;
    vin[0] = 1'b0;
    #1;
    tot_cnt++;
    if (ov[0] !== 1'b0) $display("FAIL reset_stale1: v=%b, want 0", ov[0]);
    else pass_cnt++;
    tick;
    tot_cnt++;
    if ({ov[0], olzc[0], onorm[0]} !== {1'b1, 6'd17, 32'h200000})
      $display("FAIL reset_new: v=%b lzc=%0d norm=%h, want 1/17/200000", ov[0], olzc[0], onorm[0]);
    else pass_cnt++;
    tick;
    tot_cnt++;
    if (ov[0] !== 1'b0) $display("FAIL reset_dup: v=%b, want 0", ov[0]);
    else pass_cnt++;
  endtask
  initial begin
    idle;
    test_reset;
    test_directed;
    test_backpressure;
    for (int g = 0; g < 4; g++) test_random(g);
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
